// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// Each access walks IDLE -> ACCESS -> CAPTURE -> ACK, and every output is registered.
module ram_arbiter #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          Req0,
  input  logic          Req1,
  input  logic          We0,
  input  logic          We1,
  input  logic [AW-1:0] Addr0,
  input  logic [AW-1:0] Addr1,
  input  logic [DW-1:0] WData0,
  input  logic [DW-1:0] WData1,
  output logic          Ack0,
  output logic          Ack1,
  output logic [DW-1:0] RData0,
  output logic [DW-1:0] RData1,
  output logic          Ram_We,
  output logic [AW-1:0] Ram_Addr,
  output logic [DW-1:0] Ram_Din,
  input  logic [DW-1:0] Ram_Dout,
  output logic          Busy,
  output logic          Gnt
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;
  logic          we_q, we_q_nxt;
  logic          win;
  logic          ack0_nxt, ack1_nxt, ram_we_nxt, busy_nxt, gnt_nxt;
  logic [DW-1:0] rdata0_nxt, rdata1_nxt, ram_din_nxt;
  logic [AW-1:0] ram_addr_nxt;

  // Last resets to 1 so that the first tie after reset goes to port 0.
  assign win = (Req0 && Req1) ? ~last : Req1;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values from before the edge, whatever order the statements are in.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      we_q     <= 1'b0;
      Ack0     <= 1'b0;
      Ack1     <= 1'b0;
      RData0   <= '0;
      RData1   <= '0;
      Ram_We   <= 1'b0;
      Ram_Addr <= '0;
      Ram_Din  <= '0;
      Busy     <= 1'b0;
      Gnt      <= 1'b0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      we_q     <= we_q_nxt;
      Ack0     <= ack0_nxt;
      Ack1     <= ack1_nxt;
      RData0   <= rdata0_nxt;
      RData1   <= rdata1_nxt;
      Ram_We   <= ram_we_nxt;
      Ram_Addr <= ram_addr_nxt;
      Ram_Din  <= ram_din_nxt;
      Busy     <= busy_nxt;
      Gnt      <= gnt_nxt;
    end
  end

  // NOTE: each always_comb assigns a default to every output first, so no path
  // can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (Req0 || Req1) state_nxt = ACCESS;
      ACCESS:  state_nxt = CAPTURE;
      CAPTURE: state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    last_nxt     = last;
    we_q_nxt     = we_q;
    ack0_nxt     = 1'b0;
    ack1_nxt     = 1'b0;
    rdata0_nxt   = RData0;
    rdata1_nxt   = RData1;
    ram_we_nxt   = 1'b0;
    ram_addr_nxt = Ram_Addr;
    ram_din_nxt  = Ram_Din;
    gnt_nxt      = Gnt;
    busy_nxt     = (state_nxt != IDLE);
    unique case (state)
      IDLE: begin
        if (Req0 || Req1) begin
          gnt_nxt      = win;
          ram_we_nxt   = win ? We1 : We0;
          we_q_nxt     = win ? We1 : We0;
          ram_addr_nxt = win ? Addr1 : Addr0;
          ram_din_nxt  = win ? WData1 : WData0;
        end
      end
      CAPTURE: begin
        // Ram_Dout carries the word addressed during ACCESS only in this cycle.
        if (!we_q) begin
          if (Gnt) rdata1_nxt = Ram_Dout;
          else     rdata0_nxt = Ram_Dout;
        end
        ack0_nxt = ~Gnt;
        ack1_nxt = Gnt;
        last_nxt = Gnt;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 6, meaning RAM word-address width.
REQ-002 SHALL have parameter DW, default 32, meaning RAM data width.
REQ-003 SHALL have port Clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port Rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports Req0/Req1  in  1  per-requester access request; level, held until Ack.
REQ-006 SHALL have ports We0/We1  in  1  per-requester 1=write, 0=read; held with Req.
REQ-007 SHALL have ports Addr0/Addr1  in  AW  per-requester word address; held with Req.
REQ-008 SHALL have ports WData0/WData1  in  DW  per-requester write data; held with Req.
REQ-009 SHALL have ports Ack0/Ack1  out  1  one-cycle completion pulse per requester.
REQ-010 SHALL have ports RData0/RData1  out  DW  read data per requester.
REQ-011 SHALL have port Ram_We  out  1  to single-port RAM write enable.
REQ-012 SHALL have port Ram_Addr  out  AW  to RAM address.
REQ-013 SHALL have port Ram_Din  out  DW  to RAM write data.
REQ-014 SHALL have port Ram_Dout  in  DW  from RAM; valid after the Clk edge that sampled Ram_Addr.
REQ-015 SHALL have port Busy  out  1  high whenever state is not IDLE.
REQ-016 SHALL have port Gnt  out  1  index of the requester currently or last served.

Function
REQ-017 SHALL be a four-state FSM: IDLE, ACCESS, CAPTURE, ACK; all outputs registered.
REQ-018 IDLE, edge with any Req high: SHALL pick winner, load Ram_Addr/Ram_Din/Ram_We from winner, set Gnt, go ACCESS; no Req: stay IDLE, Ram_We=0.
REQ-019 Arbitration SHALL be round-robin: single requester wins; both high, winner is the port not served last (Last register).
REQ-020 ACCESS SHALL last exactly one cycle (RAM samples address/write at its closing edge), then go CAPTURE with Ram_We cleared.
REQ-021 Ram_We SHALL be high for exactly one cycle per write access and never for a read.
REQ-022 CAPTURE edge: for reads SHALL load RData<Gnt> from Ram_Dout; for writes RData unchanged; set Ack<Gnt>=1, update Last=Gnt, go ACK.
REQ-023 ACK SHALL last exactly one cycle; at its closing edge clear Ack, go IDLE.
REQ-024 Latency: Ack high in the third cycle after the IDLE edge that sampled Req; one access per 4 cycles max.
REQ-025 Requester SHALL drop Req at the edge ending its Ack cycle; arbiter SHALL NOT sample Req outside IDLE, so no double service.
REQ-026 Req/We/Addr/WData changes outside IDLE SHALL be ignored; values latched in IDLE govern the access.
REQ-027 RData0/RData1 SHALL hold value until that port's next completed read.
REQ-028 Ack0 and Ack1 SHALL never be high in the same cycle.
REQ-029 Ram_Addr/Ram_Din SHALL hold last-driven values while IDLE.

Reset
REQ-030 Rst_n low SHALL immediately force state IDLE, Ram_We=0, Ram_Addr=0, Ram_Din=0, Ack0=Ack1=0, RData0=RData1=0, Busy=0, Gnt=0, Last=1.
REQ-031 Reset mid-access SHALL abort with no Ack; RAM content at target address is undefined if Ram_We was high at assertion.
REQ-032 After Rst_n deasserts, first tie SHALL be granted to port 0.

Verification
REQ-033 Port0 write Addr0=5, WData0=0x12345678 -> Ram_We high one cycle with Ram_Addr=5, Ram_Din=0x12345678; Ack0 one pulse 3 cycles after sample.
REQ-034 Then port1 read Addr1=5 -> Ram_We stays 0; RData1=0x12345678 when Ack1 high, held afterwards.
REQ-035 After reset, Req0=Req1=1 continuously (re-raised after each Ack) -> grants 0,1,0,1; Ack pulses 4 cycles apart, never overlapping.
REQ-036 Rst_n low during ACCESS of port0 write 0xFFFFFFFF -> all outputs zero at once, no Ack0; after release, tie grants port 0.
REQ-037 Req1 alone held with We1=1, Addr1 changed during ACCESS -> write uses address sampled in IDLE; Busy high for exactly 3 cycles.
